// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned AW          = 32;
  localparam int unsigned DW          = 32;
  localparam int unsigned DEPTH_WORDS = 32;

  localparam bit PORT_CORE = 1'b0;
  localparam bit PORT_DBG  = 1'b1;

  // Word-aligned and inside the memory's byte range.
  function automatic logic addr_legal(input logic [63:0] addr, input int unsigned depth_words);
    return (addr[1:0] == 2'b00) && (addr < (64'(depth_words) << 2));
  endfunction

endpackage

// File: rtl/dmem_rsp_slot.sv
// One registered response slot with valid/ready handshake.
module dmem_rsp_slot #(
  parameter int unsigned DW = dmem_arb_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          load_err,
  input  logic [DW-1:0] load_rdata,
  input  logic          rsp_ready,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata
);

  // Reload wins over drain so back-to-back streams keep valid high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_err   <= load_err;
      rsp_rdata <= load_rdata;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the
// core load/store unit (port 0) and the debug/DMA master (port 1).
module dmem_arbiter #(
  parameter int unsigned AW          = dmem_arb_pkg::AW,
  parameter int unsigned DW          = dmem_arb_pkg::DW,
  parameter int unsigned DEPTH_WORDS = dmem_arb_pkg::DEPTH_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req_valid,
  output logic          p0_req_ready,
  input  logic          p0_req_we,
  input  logic [AW-1:0] p0_req_addr,
  input  logic [DW-1:0] p0_req_wdata,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [DW-1:0] p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_req_valid,
  output logic          p1_req_ready,
  input  logic          p1_req_we,
  input  logic [AW-1:0] p1_req_addr,
  input  logic [DW-1:0] p1_req_wdata,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [DW-1:0] p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  import dmem_arb_pkg::*;

  logic [1:0]    elig;
  logic [1:0]    grant;
  logic          last_ptr;
  logic          any_grant;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          legal;
  logic          ld_err;
  logic [DW-1:0] ld_rdata;

  // Eligibility and round-robin grant; nothing is granted during reset.
  always_comb begin
    elig            = '0;
    grant           = '0;
    elig[PORT_CORE] = !reset && p0_req_valid && (!p0_rsp_valid || p0_rsp_ready);
    elig[PORT_DBG]  = !reset && p1_req_valid && (!p1_rsp_valid || p1_rsp_ready);
    if (elig[PORT_CORE] && elig[PORT_DBG]) begin
      if (last_ptr == PORT_DBG) grant[PORT_CORE] = 1'b1;
      else                      grant[PORT_DBG]  = 1'b1;
    end else begin
      grant = elig;
    end
  end

  assign p0_req_ready = grant[PORT_CORE];
  assign p1_req_ready = grant[PORT_DBG];
  assign any_grant    = |grant;

  // Request mux, legality check and memory strobes.
  always_comb begin
    sel_we    = grant[PORT_DBG] ? p1_req_we    : p0_req_we;
    sel_addr  = grant[PORT_DBG] ? p1_req_addr  : p0_req_addr;
    sel_wdata = grant[PORT_DBG] ? p1_req_wdata : p0_req_wdata;
    legal     = addr_legal(64'(sel_addr), DEPTH_WORDS);
    mem_write = any_grant && legal && sel_we;
    mem_read  = any_grant && legal && !sel_we;
    mem_addr  = any_grant ? sel_addr  : '0;
    mem_wdata = any_grant ? sel_wdata : '0;
    ld_err    = !legal;
    ld_rdata  = (legal && !sel_we) ? mem_rdata : '0;
  end

  // Last-grant pointer; starts at the debug port so the core wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          last_ptr <= PORT_DBG;
    else if (any_grant) last_ptr <= grant[PORT_DBG];
  end

  dmem_rsp_slot #(.DW(DW)) u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .load       (grant[PORT_CORE]),
    .load_err   (ld_err),
    .load_rdata (ld_rdata),
    .rsp_ready  (p0_rsp_ready),
    .rsp_valid  (p0_rsp_valid),
    .rsp_err    (p0_rsp_err),
    .rsp_rdata  (p0_rsp_rdata)
  );

  dmem_rsp_slot #(.DW(DW)) u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .load       (grant[PORT_DBG]),
    .load_err   (ld_err),
    .load_rdata (ld_rdata),
    .rsp_ready  (p1_rsp_ready),
    .rsp_valid  (p1_rsp_valid),
    .rsp_err    (p1_rsp_err),
    .rsp_rdata  (p1_rsp_rdata)
  );

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-ported, word-addressed data memory between the core load/store unit (port 0) and a debug/DMA master (port 1). Accepts one access per cycle with fair round-robin arbitration. Drives the memory's write/read strobes and captures combinational read data into a per-port registered response slot. Sits between the requesters and the data memory in the single-cycle RISC-V top level.

## Interface
- AW, 32, address width (byte address)
- DW, 32, data width
- DEPTH_WORDS, 32, memory depth in words; legal byte range 0 .. 4*DEPTH_WORDS-1
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- pN_req_valid  in  1  request present (N = 0, 1; same set per port)
- pN_req_ready  out  1  request accepted this cycle
- pN_req_we  in  1  1 = write, 0 = read
- pN_req_addr  in  AW  byte address
- pN_req_wdata  in  DW  write data
- pN_rsp_valid  out  1  response held in slot
- pN_rsp_ready  in  1  requester consumes response
- pN_rsp_rdata  out  DW  read data (0 for writes and errors)
- pN_rsp_err  out  1  misaligned or out-of-range access
- mem_write  out  1  memory write enable
- mem_read  out  1  memory read enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  combinational read data from memory

## Operation
- Port N is eligible when pN_req_valid && (!pN_rsp_valid || pN_rsp_ready): at most one outstanding response per port.
- Round-robin: if one port is eligible, grant it. If both are eligible, grant the port not granted last. The last-grant pointer updates only on a grant. After reset the pointer is 1, so port 0 wins the first tie.
- pN_req_ready = grant to N. At most one grant per cycle.
- For a granted request, mem_addr = req_addr and mem_wdata = req_wdata.
  - Legal access (addr[1:0]==0 and addr < 4*DEPTH_WORDS): mem_write = we, mem_read = !we.
  - Illegal access: both strobes are forced to 0, and the response carries err=1 with rdata=0.
- With no grant: mem_write = mem_read = 0, and mem_addr/mem_wdata = 0.
- Response slot N loads on grant: rsp_valid=1, rdata = mem_rdata for a legal read (0 otherwise), err as above. The slot clears on rsp_ready when not reloaded in the same cycle.
- A simultaneous drain and reload of the same slot keeps rsp_valid=1 with the new data.

## Timing
- Request accepted in cycle T. The memory write commits at the clk edge ending T. rsp_valid rises in T+1. Latency is 1 cycle.
- Aggregate throughput is 1 access/cycle. Per-port throughput is 1/cycle when alone and rsp_ready is held high, and 1 per 2 cycles when both ports contend.
- pN_req_ready depends combinationally on pN_req_valid, pN_rsp_ready and the other port's request.
- Reset values: all rsp_valid, rsp_err, rsp_rdata = 0; req_ready = 0 while reset is asserted; mem strobes = 0; pointer = 1.
- Reset mid-operation: held responses are discarded. The memory clears itself on the same reset.
- Requests must hold addr, we and wdata stable while valid and not ready. Requests must not drop valid before ready.

## Structure
- Package dmem_arb_pkg: AW/DW/DEPTH_WORDS defaults, port index constants PORT_CORE=0 and PORT_DBG=1, and an address-legality function.
- Sub-module dmem_rsp_slot: one registered response slot with valid/ready. It is instantiated once per port.
- The arbiter core (eligibility, pointer, mux) lives in dmem_arbiter.

## Test plan
- **Single read:** p0 reads addr 0x8 after a write of 0xDEADBEEF there. Required: p0_rsp_valid in the next cycle with rdata=0xDEADBEEF and err=0.
- **Contention:** both ports request every cycle with rsp_ready=1. Required: grants alternate p0, p1, p0, p1…, p0 wins the first tie after reset, and mem_write/mem_read pulse exactly once per grant.
- **Backpressure:** p1 holds rsp_ready=0 with a response pending. Required: p1_req_ready stays 0 and p0 receives every grant. When p1_rsp_ready=1, p1 is re-granted in the same cycle.
- **Illegal addresses:** p0 writes addr 0x6, then addr 0x80 (DEPTH_WORDS=32). Required: mem_write=0 for both, p0_rsp_err=1 for both, and the memory contents are unchanged.
- **Drain and reload:** a back-to-back p0 stream of reads with rsp_ready=1. Required: rsp_valid stays 1 continuously and rdata updates every cycle.
- **Reset mid-operation:** assert reset while both slots hold responses. Required: rsp_valid=0 immediately (asynchronous), and after release the first tie goes to p0.
